lane_traffic: RTL and testbench

Parametrised traffic generator for the frog game. It owns NUM_LANES horizontal lanes, each carrying CARS_PER_LANE cars. Each lane has its own frame-based speed divider and alternates direction, and cars wrap around the screen edges. The block produces a registered car-pixel flag for the VGA colour mux and a per-frame collision report against the player box, replacing the fixed four-car logic in the top level.

---
 rtl/lane_traffic_pkg.sv | 41 ++++
 rtl/lane_traffic_lane_unit.sv | 79 +++++++
 rtl/lane_traffic.sv | 111 +++++++++++
 tb/tb_lane_traffic.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_traffic_pkg.sv
// Shared constants and geometry helpers for the lane traffic generator.
package lane_traffic_pkg;

  localparam int unsigned LT_H_DISPLAY     = 640;
  localparam int unsigned LT_V_DISPLAY     = 480;
  localparam int unsigned LT_CAR_WIDTH     = 32;
  localparam int unsigned LT_CAR_HEIGHT    = 24;
  localparam int unsigned LT_PLAYER_WIDTH  = 16;
  localparam int unsigned LT_PLAYER_HEIGHT = 16;
  localparam int unsigned LT_LANE_Y0       = 320;
  localparam int unsigned LT_LANE_PITCH    = 32;
  localparam int unsigned LT_LANE_STAGGER  = 96;
  localparam int unsigned LT_STEP_BASE     = 4;

  localparam int unsigned POS_W = 11;
  typedef logic [POS_W-1:0] pos_t;

  // Car positions run over [0, WRAP) so a car fully leaves one edge before re-entering.
  function automatic int unsigned calc_wrap(input int unsigned h_display,
                                            input int unsigned car_width);
    return h_display + car_width;
  endfunction

  // Top line of a lane's car box, centred vertically within the lane pitch.
  function automatic int unsigned lane_top(input int unsigned lane,
                                           input int unsigned y0,
                                           input int unsigned pitch,
                                           input int unsigned car_h);
    return y0 + lane * pitch + (pitch - car_h) / 2;
  endfunction

  // Cars evenly spaced along the wrap, with each lane shifted by its stagger.
  function automatic pos_t reset_pos(input int unsigned car,
                                     input int unsigned cars,
                                     input int unsigned lane,
                                     input int unsigned stagger,
                                     input int unsigned wrap);
    return pos_t'((car * wrap / cars + lane * stagger) % wrap);
  endfunction

endpackage

// File: rtl/lane_traffic_lane_unit.sv
// One traffic lane: frame divider, car positions with edge wrap, per-pixel car hit.
module lane_unit
  import lane_traffic_pkg::*;
#(
  parameter int unsigned LANE_IDX      = 0,
  parameter int unsigned CARS_PER_LANE = 2,
  parameter int unsigned H_DISPLAY     = LT_H_DISPLAY,
  parameter int unsigned CAR_WIDTH     = LT_CAR_WIDTH,
  parameter int unsigned CAR_HEIGHT    = LT_CAR_HEIGHT,
  parameter int unsigned LANE_Y0       = LT_LANE_Y0,
  parameter int unsigned LANE_PITCH    = LT_LANE_PITCH,
  parameter int unsigned LANE_STAGGER  = LT_LANE_STAGGER,
  parameter logic [3:0]  DIV           = 4'd1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       move,
  input  pos_t       step,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic       car_hit
);

  localparam int unsigned WRAP      = calc_wrap(H_DISPLAY, CAR_WIDTH);
  localparam pos_t        WRAP_V    = pos_t'(WRAP);
  localparam pos_t        CW_V      = pos_t'(CAR_WIDTH);
  localparam pos_t        Y_TOP_V   = pos_t'(lane_top(LANE_IDX, LANE_Y0, LANE_PITCH, CAR_HEIGHT));
  localparam pos_t        Y_BOT_V   = Y_TOP_V + pos_t'(CAR_HEIGHT);
  localparam logic [4:0]  DIV_EFF   = (DIV == 4'd0) ? 5'd1 : {1'b0, DIV};
  localparam bit          MOVE_LEFT = (LANE_IDX % 2) == 1;

  pos_t                     pos     [CARS_PER_LANE];
  pos_t                     pos_nxt [CARS_PER_LANE];
  logic [3:0]               div_cnt;
  logic                     lane_tick;
  logic [CARS_PER_LANE-1:0] in_x;
  pos_t                     hx;
  pos_t                     vv;

  assign lane_tick = move && (({1'b0, div_cnt} + 5'd1) == DIV_EFF);

  // Next positions after one lane move, wrapping at either edge.
  always_comb begin
    pos_nxt = pos;
    for (int unsigned j = 0; j < CARS_PER_LANE; j++) begin
      if (MOVE_LEFT)
        pos_nxt[j] = (pos[j] < step) ? (pos[j] + WRAP_V - step) : (pos[j] - step);
      else
        pos_nxt[j] = ((pos[j] + step) >= WRAP_V) ? (pos[j] + step - WRAP_V) : (pos[j] + step);
    end
  end

  // Divider counter and car positions advance only on enabled frame starts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      for (int unsigned j = 0; j < CARS_PER_LANE; j++)
        pos[j] <= reset_pos(j, CARS_PER_LANE, LANE_IDX, LANE_STAGGER, WRAP);
    end else if (move) begin
      if (lane_tick) begin
        div_cnt <= '0;
        pos     <= pos_nxt;
      end else begin
        div_cnt <= div_cnt + 4'd1;
      end
    end
  end

  // Pixel-in-car test; h is offset by CAR_WIDTH so the left edge pos-CAR_WIDTH never goes negative.
  always_comb begin
    hx = {1'b0, h_count} + CW_V;
    vv = {1'b0, v_count};
    in_x = '0;
    for (int unsigned j = 0; j < CARS_PER_LANE; j++)
      in_x[j] = (pos[j] <= hx) && (hx < (pos[j] + CW_V));
    car_hit = (vv >= Y_TOP_V) && (vv < Y_BOT_V) && (|in_x);
  end

endmodule

// File: rtl/lane_traffic.sv
// Multi-lane traffic generator: car pixel flag and per-frame player collision report.
module lane_traffic
  import lane_traffic_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned CARS_PER_LANE = 2,
  parameter int unsigned H_DISPLAY     = LT_H_DISPLAY,
  parameter int unsigned V_DISPLAY     = LT_V_DISPLAY,
  parameter int unsigned CAR_WIDTH     = LT_CAR_WIDTH,
  parameter int unsigned CAR_HEIGHT    = LT_CAR_HEIGHT,
  parameter int unsigned PLAYER_WIDTH  = LT_PLAYER_WIDTH,
  parameter int unsigned PLAYER_HEIGHT = LT_PLAYER_HEIGHT,
  parameter int unsigned LANE_Y0       = LT_LANE_Y0,
  parameter int unsigned LANE_PITCH    = LT_LANE_PITCH,
  parameter int unsigned LANE_STAGGER  = LT_LANE_STAGGER,
  parameter int unsigned STEP_BASE     = LT_STEP_BASE,
  parameter logic [31:0] LANE_DIV      = 32'h0000_1212
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic       frame_start,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [2:0] level,
  output logic       car_pixel,
  output logic       collision,
  output logic [2:0] collision_lane
);

  logic [NUM_LANES-1:0] car_hit;
  logic [NUM_LANES-1:0] player_hit;
  logic                 move;
  pos_t                 step;
  pos_t                 hh;
  pos_t                 vv;
  logic                 active;
  logic                 in_player;
  logic                 any_hit;
  logic [2:0]           hit_lane;
  logic                 hit_pending;
  logic [2:0]           pend_lane;

  assign move = frame_start & enable;
  assign step = pos_t'(STEP_BASE) + pos_t'(level);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_unit #(
      .LANE_IDX      (gi),
      .CARS_PER_LANE (CARS_PER_LANE),
      .H_DISPLAY     (H_DISPLAY),
      .CAR_WIDTH     (CAR_WIDTH),
      .CAR_HEIGHT    (CAR_HEIGHT),
      .LANE_Y0       (LANE_Y0),
      .LANE_PITCH    (LANE_PITCH),
      .LANE_STAGGER  (LANE_STAGGER),
      .DIV           (LANE_DIV[4*gi +: 4])
    ) u_lane (
      .CLK     (CLK),
      .RST     (RST),
      .move    (move),
      .step    (step),
      .h_count (h_count),
      .v_count (v_count),
      .car_hit (car_hit[gi])
    );
  end

  // Active-area, player-box and lowest-lane priority decode for the current pixel.
  always_comb begin
    hh        = {1'b0, h_count};
    vv        = {1'b0, v_count};
    active    = (hh < pos_t'(H_DISPLAY)) && (vv < pos_t'(V_DISPLAY));
    in_player = (hh >= {1'b0, player_x}) && (hh < ({1'b0, player_x} + pos_t'(PLAYER_WIDTH))) &&
                (vv >= {1'b0, player_y}) && (vv < ({1'b0, player_y} + pos_t'(PLAYER_HEIGHT)));
    player_hit = car_hit & {NUM_LANES{in_player & active}};
    any_hit    = |player_hit;
    hit_lane   = '0;
    for (int unsigned k = NUM_LANES; k > 0; k--)
      if (player_hit[k-1]) hit_lane = 3'(k - 1);
  end

  // Registered pixel flag; sticky per-frame hit reported as a pulse at frame start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      car_pixel      <= 1'b0;
      collision      <= 1'b0;
      collision_lane <= '0;
      hit_pending    <= 1'b0;
      pend_lane      <= '0;
    end else begin
      car_pixel <= active & (|car_hit);
      if (frame_start) begin
        collision   <= hit_pending & enable;
        hit_pending <= 1'b0;
        if (hit_pending & enable) collision_lane <= pend_lane;
      end else begin
        collision <= 1'b0;
        if (!enable) begin
          hit_pending <= 1'b0;
        end else if (any_hit) begin
          hit_pending <= 1'b1;
          if (!hit_pending || (hit_lane < pend_lane)) pend_lane <= hit_lane;
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_traffic.sv
module tb_lane_traffic;

  localparam int NL     = 4;
  localparam int NC     = 2;
  localparam int WRAP   = 672;
  localparam int CW     = 32;
  localparam int CH     = 24;
  localparam int PW     = 16;
  localparam int PH     = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic       frame_start;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [2:0] level;
  logic       car_pixel;
  logic       collision;
  logic [2:0] collision_lane;

  lane_traffic #(
    .NUM_LANES     (NL),
    .CARS_PER_LANE (NC),
    .LANE_DIV      (32'h0000_1212)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .enable         (enable),
    .frame_start    (frame_start),
    .h_count        (h_count),
    .v_count        (v_count),
    .player_x       (player_x),
    .player_y       (player_y),
    .level          (level),
    .car_pixel      (car_pixel),
    .collision      (collision),
    .collision_lane (collision_lane)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mpos [NL][NC];
  int mcnt [NL];
  int mdiv [NL] = '{2, 1, 2, 1};
  bit pending;
  int plane;
  bit exp_col;
  int exp_lane;
  bit exp_pix;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_pos(input int l, input int c);
    case (l)
      0:       return 32'(dut.g_lane[0].u_lane.pos[c]);
      1:       return 32'(dut.g_lane[1].u_lane.pos[c]);
      2:       return 32'(dut.g_lane[2].u_lane.pos[c]);
      default: return 32'(dut.g_lane[3].u_lane.pos[c]);
    endcase
  endfunction

  function automatic bit m_in_car(input int l, input int c, input int h, input int v);
    int top, left;
    top  = 320 + l * 32 + (32 - CH) / 2;
    left = mpos[l][c] - CW;
    return (v >= top) && (v < top + CH) && (h >= left) && (h < left + CW);
  endfunction

  function automatic bit m_pix(input int h, input int v);
    if (h >= 640 || v >= 480) return 1'b0;
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < NC; c++)
        if (m_in_car(l, c, h, v)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_hit_lane(input int h, input int v);
    int px, py;
    px = int'(player_x);
    py = int'(player_y);
    if (h >= 640 || v >= 480) return -1;
    if (!(h >= px && h < px + PW && v >= py && v < py + PH)) return -1;
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < NC; c++)
        if (m_in_car(l, c, h, v)) return l;
    return -1;
  endfunction

  task automatic m_reset();
    for (int l = 0; l < NL; l++) begin
      mcnt[l] = 0;
      for (int c = 0; c < NC; c++)
        mpos[l][c] = (c * WRAP / NC + l * 96) % WRAP;
    end
    pending  = 1'b0;
    plane    = 0;
    exp_col  = 1'b0;
    exp_lane = 0;
  endtask

  task automatic m_move(input int lvl);
    int st;
    st = 4 + lvl;
    for (int l = 0; l < NL; l++) begin
      mcnt[l]++;
      if (mcnt[l] == mdiv[l]) begin
        mcnt[l] = 0;
        for (int c = 0; c < NC; c++)
          if (l % 2 == 0) mpos[l][c] = (mpos[l][c] + st) % WRAP;
          else            mpos[l][c] = (mpos[l][c] - st + WRAP) % WRAP;
      end
    end
  endtask

  task automatic check_pos();
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < NC; c++)
        check($sformatf("pos_l%0d_c%0d", l, c), get_pos(l, c), mpos[l][c]);
  endtask

  // One clock with the current inputs: update model, advance, compare outputs.
  task automatic cyc();
    int hl;
    hl      = m_hit_lane(int'(h_count), int'(v_count));
    exp_pix = m_pix(int'(h_count), int'(v_count));
    if (frame_start) begin
      exp_col = pending && enable;
      if (exp_col) exp_lane = plane;
      pending = 1'b0;
      if (enable) m_move(int'(level));
    end else begin
      exp_col = 1'b0;
      if (!enable) pending = 1'b0;
      else if (hl >= 0) begin
        if (!pending || hl < plane) plane = hl;
        pending = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
    check("car_pixel", 32'(car_pixel), int'(exp_pix));
    check("collision", 32'(collision), int'(exp_col));
    check("collision_lane", 32'(collision_lane), exp_lane);
  endtask

  task automatic pixel(input int h, input int v);
    h_count = 10'(h);
    v_count = 10'(v);
    cyc();
  endtask

  task automatic fs_begin(input bit en, input int lvl);
    enable      = en;
    level       = 3'(lvl);
    h_count     = 10'd700;
    v_count     = 10'd500;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic frame(input bit en, input int lvl);
    fs_begin(en, lvl);
    check_pos();
    cyc();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    m_reset();
    check_pos();
    check("rst_car_pixel", 32'(car_pixel), 0);
    check("rst_collision", 32'(collision), 0);
    check("rst_collision_lane", 32'(collision_lane), 0);
    RST = 1'b0;
  endtask

  initial begin
    RST         = 1'b0;
    enable      = 1'b0;
    frame_start = 1'b0;
    h_count     = 10'd700;
    v_count     = 10'd500;
    player_x    = 10'd0;
    player_y    = 10'd0;
    level       = 3'd0;
    #1;

    // Reset values
    do_reset();
    check("rst_l0c1", get_pos(0, 1), 336);
    check("rst_l1c0", get_pos(1, 0), 96);
    check("rst_l1c1", get_pos(1, 1), 432);

    // First moves: lane1 every frame, lane0 every second frame
    frame(1'b1, 0);
    check("l1c0_after1", get_pos(1, 0), 92);
    check("l0c0_after1", get_pos(0, 0), 0);
    frame(1'b1, 0);
    check("l0c0_after2", get_pos(0, 0), 4);

    // Left wrap on lane1
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      frame(1'b1, 0);
      if (k == 24) check("l1c0_at_zero", get_pos(1, 0), 0);
    end
    check("l1c0_left_wrap", get_pos(1, 0), 668);

    // Maximum level, many right and left wraps with remainders
    do_reset();
    repeat (130) frame(1'b1, 7);

    // Pixel edges of lane1 car0 (screen x 64..95, lines 356..379)
    do_reset();
    enable = 1'b1;
    pixel(64, 356);  check("pix_left_edge", 32'(car_pixel), 1);
    pixel(96, 356);  check("pix_past_right", 32'(car_pixel), 0);
    pixel(63, 356);  check("pix_before_left", 32'(car_pixel), 0);
    pixel(95, 379);  check("pix_bottom_right", 32'(car_pixel), 1);
    pixel(64, 380);  check("pix_below", 32'(car_pixel), 0);
    pixel(64, 480);  check("pix_v_blank", 32'(car_pixel), 0);
    pixel(1000, 356); check("pix_h_blank", 32'(car_pixel), 0);

    // Collision on lane1
    do_reset();
    enable   = 1'b1;
    player_x = 10'd70;
    player_y = 10'd360;
    for (int v = 340; v <= 400; v++)
      for (int h = 40; h <= 120; h++) pixel(h, v);
    fs_begin(1'b1, 0);
    check("col_pulse", 32'(collision), 1);
    check("col_lane", 32'(collision_lane), 1);
    cyc();
    check("col_one_cycle", 32'(collision), 0);

    // Player away from traffic: no pulse, lane holds
    player_y = 10'd100;
    for (int v = 90; v <= 120; v++)
      for (int h = 40; h <= 120; h++) pixel(h, v);
    fs_begin(1'b1, 0);
    check("nocol_pulse", 32'(collision), 0);
    check("nocol_lane_hold", 32'(collision_lane), 1);
    cyc();

    // Reset mid-frame discards a pending hit
    do_reset();
    enable   = 1'b1;
    player_x = 10'd70;
    player_y = 10'd360;
    pixel(70, 360);
    pixel(75, 365);
    do_reset();
    fs_begin(1'b1, 0);
    check("rst_midframe_col", 32'(collision), 0);
    cyc();

    // Disabled: positions hold, hits dropped
    do_reset();
    enable = 1'b0;
    pixel(70, 360);
    repeat (5) frame(1'b0, 3);
    check("dis_l1c0_hold", get_pos(1, 0), 96);
    pixel(72, 362);
    fs_begin(1'b1, 0);
    check("dis_no_col", 32'(collision), 0);
    cyc();

    // Randomized frames with pixels biased around the player
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int hh, vv;
      player_x = 10'($urandom_range(0, 620));
      player_y = 10'($urandom_range(320, 460));
      enable   = ($urandom_range(0, 7) != 0);
      for (int p = 0; p < 200; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          hh = int'(player_x) + int'($urandom_range(0, 32)) - 8;
          vv = int'(player_y) + int'($urandom_range(0, 32)) - 8;
          if (hh < 0) hh = 0;
          if (vv < 0) vv = 0;
        end else begin
          hh = int'($urandom_range(0, 700));
          vv = int'($urandom_range(300, 500));
        end
        pixel(hh, vv);
      end
      frame(enable, int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
